call_stack: RTL
===============

CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of 16-bit return-address entries (power of two, 2..64).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port push  input  1  a call request; capture d_bus onto the stack at this edge (the program counter drives d_bus in the same cycle).
REQ-005 The block SHALL have port pop  input  1  a return request; drive the top entry onto d_bus this cycle and remove it at this edge (the program counter loads from d_bus in the same cycle).
REQ-006 The block SHALL have port d_bus  inout  16  the shared data bus; driven only as stated in REQ-012, otherwise high-impedance.
REQ-007 The block SHALL have port empty  output  1  high when the stack holds zero entries.
REQ-008 The block SHALL have port full  output  1  high when the stack holds DEPTH entries.
REQ-009 The block SHALL have port depth  output  7  the current entry count, 0..DEPTH.
REQ-010 The block SHALL have port fault  output  1  sticky error flag: overflow, underflow or push/pop conflict.

Function
REQ-011 On a push with push=1, pop=0 and full=0, the block SHALL write d_bus into entry[depth] and increment depth by 1 at the same edge; the new top is readable in the next cycle.
REQ-012 While pop=1, push=0 and empty=0, the block SHALL drive d_bus combinationally with entry[depth-1] for the whole cycle, with zero-cycle latency from pop.
REQ-013 On that pop cycle, depth SHALL decrement by 1 at the clock edge.
REQ-014 In every other case d_bus SHALL be 16'bz, including pop while empty, push=pop=1, and rst_n=0.
REQ-015 On a push while full=1, the block SHALL leave storage and depth unchanged (the push is dropped, no wrap-around) and set fault at the edge.
REQ-016 On a pop while empty=1, the block SHALL leave depth at 0, not drive d_bus, and set fault at the edge.
REQ-017 When push=1 and pop=1 in the same cycle, the block SHALL perform neither operation, leave depth unchanged and d_bus undriven, and set fault at the edge.
REQ-018 The empty, full and depth outputs SHALL be decoded from the registered count only, with no combinational path from push or pop.
REQ-019 Once set, fault SHALL remain high until rst_n=0; later legal operations SHALL still execute normally.
REQ-020 Entry contents at or above the current depth SHALL never be observable on d_bus.
REQ-021 Back-to-back operations (push, push, pop, pop ...) SHALL be accepted every cycle with no idle cycles required.

Reset
REQ-022 With rst_n=0 at a rising edge, the block SHALL set depth=0, empty=1, full=0 and fault=0 regardless of push or pop.
REQ-023 While rst_n=0, the block SHALL keep d_bus high-impedance; entry storage need not be cleared.
REQ-024 A reset asserted during a push or pop cycle SHALL override that operation, so no entry is written and no decrement occurs.

Verification
REQ-025 Reset, then push with d_bus=16'h0010, then 16'h0123 (two cycles) -> depth=2, empty=0; pop cycle 1 shows d_bus=16'h0123; pop cycle 2 shows d_bus=16'h0010; then empty=1, fault=0.
REQ-026 Reset, then DEPTH pushes of 16'h1000+i -> full=1, depth=DEPTH; one more push of 16'hFFFF -> depth unchanged, fault=1; DEPTH pops return 16'h1000+DEPTH-1 down to 16'h1000.
REQ-027 Reset, then pop with stack empty -> d_bus=Z that cycle, depth=0, fault=1 next cycle; a following push of 16'h00AA and pop returns 16'h00AA.
REQ-028 With depth=1 holding 16'h0042, assert push=pop=1 with d_bus externally driven to 16'h0099 -> block does not drive d_bus, depth=1, fault=1; a subsequent pop returns 16'h0042.
REQ-029 With depth=3, assert rst_n=0 in the same cycle as push=1 -> next cycle depth=0, empty=1, fault=0, d_bus=Z; a pop then sets fault.
REQ-030 Drive alternating push/pop every cycle for 100 cycles with random 16-bit data against a reference model -> every popped value matches, and d_bus is Z on all non-pop cycles.

Source files
------------

// File: rtl/call_stack.sv
// Return-address stack for a CPU call/return path: push captures the PC from the
// shared bus, pop drives the top entry back onto the bus in the same cycle.
module call_stack #(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   inout  wire [15:0] d_bus,
   output logic       empty,
   output logic       full,
   output logic [6:0] depth,
   output logic       fault
);

   localparam int unsigned DW = 16;
   localparam int unsigned CW = 7;
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0] count_q, count_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          fault_q, fault_d;
   logic [DW-1:0] mem_q [DEPTH];

   logic          push_ok_c;
   logic          pop_ok_c;
   logic          err_c;
   logic          drive_c;
   logic [AW-1:0] wr_idx_c;
   logic [AW-1:0] rd_idx_c;

   // Qualify requests against the registered occupancy; simultaneous push/pop is an error.
   always_comb begin
      push_ok_c = push & ~pop & ~full_q;
      pop_ok_c  = pop & ~push & ~empty_q;
      err_c     = (push & pop) | (push & ~pop & full_q) | (pop & ~push & empty_q);
      drive_c   = pop_ok_c & rst_n;
      wr_idx_c  = AW'(count_q);
      rd_idx_c  = AW'(count_q - CW'(1));
   end

   // Next occupancy and flags; flags are pre-decoded so outputs come straight from flops.
   always_comb begin
      count_d = count_q;
      fault_d = fault_q | err_c;
      if (push_ok_c) begin
         count_d = count_q + CW'(1);
      end else if (pop_ok_c) begin
         count_d = count_q - CW'(1);
      end
      empty_d = (count_d == CW'(0));
      full_d  = (count_d == CW'(DEPTH));
   end

   // Occupancy and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= CW'(0);
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         count_q <= count_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         fault_q <= fault_d;
      end
   end

   // Entry storage; not cleared by reset since stale entries are never readable.
   always_ff @(posedge clk) begin
      if (rst_n && push_ok_c) begin
         mem_q[wr_idx_c] <= d_bus;
      end
   end

   // Top entry is driven only on a legal pop outside reset; otherwise the bus is released.
   assign d_bus = drive_c ? mem_q[rd_idx_c] : {DW{1'bz}};

   assign empty = empty_q;
   assign full  = full_q;
   assign depth = count_q;
   assign fault = fault_q;

endmodule
